pulse_width_meas: RTL
=====================

Name: pulse_width_meas

Overview:
Receive-side companion to the team's counter-based pulse stretcher. The stretcher emits fixed-length high pulses on a single line; this block recovers them. It synchronises an asynchronous pulse line, measures the high time of each pulse in clk cycles, and reports the width with a one-cycle valid strobe. It also flags whether the width matches the expected stretch length, flags counter saturation, and keeps a wrapping count of matched pulses.

Parameters:
CNT_W, 16, width of the measurement counter and width_out (min 4)
EXP_LEN, 10, expected pulse length in clk cycles (1 .. 2^CNT_W-2)
TOL, 0, allowed +/- deviation from EXP_LEN for match

Ports:
clk  input  1  clock, all logic rising-edge
rstn  input  1  asynchronous active-low reset
din  input  1  asynchronous pulse line from stretcher
clr  input  1  synchronous clear; aborts any measurement and zeroes pulse_cnt
width_out  output  CNT_W  measured high width of last completed pulse
width_vld  output  1  one-cycle strobe; width_out/match/ovf valid this cycle
match  output  1  width within [EXP_LEN-TOL, EXP_LEN+TOL] and not ovf
ovf  output  1  pulse reached counter saturation (2^CNT_W-1)
busy  output  1  high while in MEAS state
pulse_cnt  output  8  count of matched pulses, wraps 255->0

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. All outputs 0, both sync FFs 0, prev-sample FF 0, state WAIT_LOW.
- Sync: 2-FF synchroniser on din -> s. prev = s delayed one cycle. rise = s & ~prev. fall = ~s & prev.
- States:
  - WAIT_LOW: ignores din high; -> IDLE when s==0. Prevents measuring a partial pulse after reset or clr.
  - IDLE: on rise: cnt<=1, -> MEAS.
  - MEAS: busy=1. While s==1: cnt<=cnt+1, saturating at 2^CNT_W-1 (no wrap); sat flag set when cnt reaches max. On s==0: -> IDLE and emit result.
- Emit, registered on the edge leaving MEAS:
  - width_out<=cnt, width_vld<=1 for exactly one cycle.
  - ovf<=sat.
  - match<=(~sat) & (cnt>=EXP_LEN-TOL) & (cnt<=EXP_LEN+TOL); lower bound clamps at 1.
  - If match, pulse_cnt<=pulse_cnt+1, wrapping.
- Output hold: width_out, match and ovf hold until the next emit. width_vld is 0 otherwise.
- Width semantics: width = number of clk rising edges at which synchronised s was high. A din high for N whole cycles gives width N. The minimum reportable pulse is 1.
- Latency: width_vld is high in the cycle after the 3rd clk edge following the first edge that samples din low (2 sync stages + 1 output register).
- Back-to-back pulses: a one-cycle low gap must be handled. The MEAS->IDLE emit cycle and the IDLE rise detection happen on consecutive edges, so no pulse is lost.
- clr: synchronous, highest priority after reset.
  - State<=WAIT_LOW, cnt<=0, sat<=0, width_vld<=0, pulse_cnt<=0.
  - width_out, match and ovf keep their last values.
  - No emit for an aborted pulse.
- clr on the same edge as an emit: clr wins; no width_vld.
- Reset mid-pulse: state returns to WAIT_LOW. The remainder of the pulse is discarded; the next complete pulse is measured normally.

Test Plan:
- rstn low 5 cycles, din low, then 10-cycle din high (EXP_LEN=10, TOL=0) -> single width_vld, width_out=10, match=1, ovf=0, pulse_cnt=1, busy high 10 cycles.
- Pulses of 9 then 11 cycles, each followed by a 5-cycle gap -> two strobes: width 9 then 11, match=0 both, pulse_cnt unchanged. Repeat with TOL=1 -> match=1 both, pulse_cnt +2.
- Three 10-cycle pulses separated by 1-cycle low gaps -> three strobes, each width_out=10, pulse_cnt=3; 1-cycle din pulse -> width_out=1.
- CNT_W=4, 20-cycle pulse -> one strobe, width_out=15, ovf=1, match=0; following 10-cycle pulse -> ovf=0, width_out=10.
- clr asserted 1 cycle at cycle 5 of a 10-cycle pulse -> no width_vld for that pulse, pulse_cnt=0; next 10-cycle pulse -> width_out=10, pulse_cnt=1.
- din held high through and after reset release for 8 cycles, then low, then 10-cycle pulse -> no strobe for the partial pulse; one strobe width_out=10. pulse_cnt wrap: 256 matched pulses -> pulse_cnt=0.

Source files
------------

// File: rtl/pulse_width_meas_if.sv
// pulse_width_meas_if: pulse line and clear in, width measurement results out
interface pulse_width_meas_if #(parameter int CNT_W = 16);
    logic             din;
    logic             clr;
    logic [CNT_W-1:0] width_out;
    logic             width_vld;
    logic             match;
    logic             ovf;
    logic             busy;
    logic [7:0]       pulse_cnt;
    modport master (output din, clr, input width_out, width_vld, match, ovf, busy, pulse_cnt);
    modport slave (input din, clr, output width_out, width_vld, match, ovf, busy, pulse_cnt);
endinterface

// File: rtl/pulse_width_meas.sv
// pulse_width_meas: synchronises din, measures each high pulse in clk cycles and reports width/match/ovf
module pulse_width_meas #(
    parameter int CNT_W   = 16,
    parameter int EXP_LEN = 10,
    parameter int TOL     = 0
) (
    input logic               clk,
    input logic               rstn,
    pulse_width_meas_if.slave io
);
    typedef enum logic [1:0] {WAIT_LOW, IDLE, MEAS} state_t;
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam int LO = (EXP_LEN - TOL < 1) ? 1 : EXP_LEN - TOL;
    localparam int HI = EXP_LEN + TOL;
    state_t           state;
    logic [1:0]       sync;
    logic [1:0]       prime;
    logic             prev;
    logic             sat;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             rise;
    logic             hit;
    assign s    = sync[1];
    assign rise = s & ~prev;
    assign hit  = ~sat & (int'(cnt) >= LO) & (int'(cnt) <= HI);
    // prime marks when s first reflects real din after reset, so a line held
    // high through reset is not mistaken for a fresh rising edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync         <= '0;
            prime        <= '0;
            prev         <= 1'b0;
            state        <= WAIT_LOW;
            cnt          <= '0;
            sat          <= 1'b0;
            io.width_out <= '0;
            io.width_vld <= 1'b0;
            io.match     <= 1'b0;
            io.ovf       <= 1'b0;
            io.busy      <= 1'b0;
            io.pulse_cnt <= '0;
        end else begin
            sync         <= {sync[0], io.din};
            prime        <= {prime[0], 1'b1};
            prev         <= s;
            io.width_vld <= 1'b0;
            if (io.clr) begin
                state        <= WAIT_LOW;
                cnt          <= '0;
                sat          <= 1'b0;
                io.busy      <= 1'b0;
                io.pulse_cnt <= '0;
            end else begin
                case (state)
                    WAIT_LOW: if (prime[1] && !s) state <= IDLE;
                    IDLE: if (rise) begin
                        cnt     <= CNT_W'(1);
                        sat     <= 1'b0;
                        io.busy <= 1'b1;
                        state   <= MEAS;
                    end
                    MEAS: if (s) begin
                        if (cnt != MAX) cnt <= cnt + 1'b1;
                        if (cnt >= MAX - 1'b1) sat <= 1'b1;
                    end else begin
                        state        <= IDLE;
                        io.busy      <= 1'b0;
                        io.width_out <= cnt;
                        io.width_vld <= 1'b1;
                        io.ovf       <= sat;
                        io.match     <= hit;
                        if (hit) io.pulse_cnt <= io.pulse_cnt + 8'd1;
                    end
                    default: state <= WAIT_LOW;
                endcase
            end
        end
    end
endmodule
